uart_text_ctrl: RTL

//  Sequencer between the UART receiver and the VGA character buffer. Takes received bytes,

---
 rtl/uart_text_pkg.sv | 37 +++
 rtl/uart_text_ctrl_if.sv | 28 ++
 rtl/uart_text_cursor.sv | 93 +++++++++
 rtl/uart_text_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_text_pkg.sv
// Shared types and constants for the UART-to-text-buffer sequencer: FSM and
// cursor-operation encodings, control character codes and default screen size.
package uart_text_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_ESC   = 8'h1B;
  localparam logic [7:0] CHR_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_ESC_COL = 3'd3,
    ST_ESC_ROW = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CUR_NOP  = 3'd0,
    CUR_ADV  = 3'd1,
    CUR_LF   = 3'd2,
    CUR_CR   = 3'd3,
    CUR_BS   = 3'd4,
    CUR_LOAD = 3'd5,
    CUR_ZERO = 3'd6
  } cur_op_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/uart_text_ctrl_if.sv
// Byte-in / character-buffer-write-out bundle of uart_text_ctrl.
// slave is the controller side, master the side feeding bytes and watching writes.
interface uart_text_ctrl_if #(
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5,
  parameter int ADDR_W = 12
);
  logic              rx_valid_i;
  logic [7:0]        rx_data_i;
  logic              overflow_clr_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [7:0]        wr_data_o;
  logic [COL_W-1:0]  cursor_col_o;
  logic [ROW_W-1:0]  cursor_row_o;
  logic              busy_o;
  logic              overflow_o;

  modport slave (
    input  rx_valid_i, rx_data_i, overflow_clr_i,
    output wr_en_o, wr_addr_o, wr_data_o, cursor_col_o, cursor_row_o, busy_o, overflow_o
  );

  modport master (
    output rx_valid_i, rx_data_i, overflow_clr_i,
    input  wr_en_o, wr_addr_o, wr_data_o, cursor_col_o, cursor_row_o, busy_o, overflow_o
  );
endinterface

// File: rtl/uart_text_cursor.sv
// Text cursor (col,row) with a running row base so the cell address is base+col,
// avoiding a row*COLS multiply on every write.
module uart_text_cursor
  import uart_text_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  cur_op_e           op_i,
  input  logic [COL_W-1:0]  ld_col_i,
  input  logic [ROW_W-1:0]  ld_row_i,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ROW_W-1:0]  row_inc;
  logic [ADDR_W-1:0] base_inc;

  // Loads pick the row base from a table of constants rather than multiplying.
  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] r);
    logic [ADDR_W-1:0] acc;
    logic [ADDR_W-1:0] res;
    acc = '0;
    res = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (r == ROW_W'(i)) res = acc;
      acc = acc + ADDR_W'(COLS);
    end
    return res;
  endfunction

  always_comb begin
    row_inc  = (row_q == ROW_W'(ROWS-1)) ? '0 : row_q + ROW_W'(1);
    base_inc = (row_q == ROW_W'(ROWS-1)) ? '0 : base_q + ADDR_W'(COLS);
    col_d    = col_q;
    row_d    = row_q;
    base_d   = base_q;
    case (op_i)
      CUR_ADV: begin
        if (col_q == COL_W'(COLS-1)) begin
          col_d  = '0;
          row_d  = row_inc;
          base_d = base_inc;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      CUR_LF: begin
        row_d  = row_inc;
        base_d = base_inc;
      end
      CUR_CR: col_d = '0;
      CUR_BS: if (col_q != '0) col_d = col_q - COL_W'(1);
      CUR_LOAD: begin
        col_d  = ld_col_i;
        row_d  = ld_row_i;
        base_d = row_base(ld_row_i);
      end
      CUR_ZERO: begin
        col_d  = '0;
        row_d  = '0;
        base_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = base_q + ADDR_W'(col_q);

endmodule

// File: rtl/uart_text_ctrl.sv
// Decodes UART bytes into character-buffer writes and cursor moves, with a
// form-feed clear sweep. Define UART_TEXT_GOTO_EN to enable ESC,col,row cursor positioning.
module uart_text_ctrl
  import uart_text_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5,
  parameter int ADDR_W = 12
) (
  input logic              clk_i,
  input logic              rstn_i,
  uart_text_ctrl_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS*ROWS - 1);

  state_e            state_q, state_d;
  logic              rx_valid_q;
  logic              pend_valid_q, pend_valid_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        char_q, char_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;

  logic              new_byte;
  logic              pend_take;
  cur_op_e           cur_op;
  logic [COL_W-1:0]  ld_col;
  logic [ROW_W-1:0]  ld_row;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [ADDR_W-1:0] cur_addr;

`ifdef UART_TEXT_GOTO_EN
  logic [COL_W-1:0] goto_col_q, goto_col_d;

  function automatic logic [COL_W-1:0] clamp_col(input logic [7:0] b);
    if (int'(b) > COLS-1) return COL_W'(COLS-1);
    return COL_W'(b);
  endfunction

  function automatic logic [ROW_W-1:0] clamp_row(input logic [7:0] b);
    if (int'(b) > ROWS-1) return ROW_W'(ROWS-1);
    return ROW_W'(b);
  endfunction
`endif

  uart_text_cursor #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
  ) u_cursor (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .op_i     (cur_op),
    .ld_col_i (ld_col),
    .ld_row_i (ld_row),
    .col_o    (cur_col),
    .row_o    (cur_row),
    .addr_o   (cur_addr)
  );

  always_comb begin
    state_d    = state_q;
    char_d     = char_q;
    clr_addr_d = clr_addr_q;
    pend_take  = 1'b0;
    cur_op     = CUR_NOP;
    ld_col     = '0;
    ld_row     = '0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef UART_TEXT_GOTO_EN
    goto_col_d = goto_col_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          pend_take = 1'b1;
          if (is_printable(pend_data_q)) begin
            char_d  = pend_data_q;
            state_d = ST_WRITE;
          end else begin
            case (pend_data_q)
              CHR_BS: begin
                if (cur_col != '0) begin
                  char_d  = CHR_BS;
                  state_d = ST_WRITE;
                end
              end
              CHR_CR: cur_op = CUR_CR;
              CHR_LF: cur_op = CUR_LF;
              CHR_FF: begin
                clr_addr_d = '0;
                state_d    = ST_CLEAR;
              end
`ifdef UART_TEXT_GOTO_EN
              CHR_ESC: state_d = ST_ESC_COL;
`endif
              default: ;
            endcase
          end
        end
      end
      ST_WRITE: begin
        // Backspace blanks the cell left of the cursor while stepping back onto it.
        wr_en_d = 1'b1;
        state_d = ST_IDLE;
        if (char_q == CHR_BS) begin
          wr_addr_d = cur_addr - ADDR_W'(1);
          wr_data_d = CHR_SPACE;
          cur_op    = CUR_BS;
        end else begin
          wr_addr_d = cur_addr;
          wr_data_d = char_q;
          cur_op    = CUR_ADV;
        end
      end
      ST_CLEAR: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = clr_addr_q;
        wr_data_d  = CHR_SPACE;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == LAST_CELL) begin
          state_d = ST_IDLE;
          cur_op  = CUR_ZERO;
        end
      end
`ifdef UART_TEXT_GOTO_EN
      ST_ESC_COL: begin
        if (pend_valid_q) begin
          pend_take  = 1'b1;
          goto_col_d = clamp_col(pend_data_q);
          state_d    = ST_ESC_ROW;
        end
      end
      ST_ESC_ROW: begin
        if (pend_valid_q) begin
          pend_take = 1'b1;
          cur_op    = CUR_LOAD;
          ld_col    = goto_col_q;
          ld_row    = clamp_row(pend_data_q);
          state_d   = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Busy also covers the trailing registered write after the FSM returns to IDLE.
    busy_d = (state_d != ST_IDLE) || wr_en_d;
  end

  always_comb begin
    new_byte     = bus.rx_valid_i && !rx_valid_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    overflow_d   = overflow_q;
    if (pend_take) pend_valid_d = 1'b0;
    if (new_byte && (!pend_valid_q || pend_take)) begin
      pend_valid_d = 1'b1;
      pend_data_d  = bus.rx_data_i;
    end
    if (bus.overflow_clr_i) overflow_d = 1'b0;
    if (new_byte && pend_valid_q && !pend_take) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      rx_valid_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      overflow_q   <= 1'b0;
      char_q       <= '0;
      clr_addr_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_valid_q   <= bus.rx_valid_i;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      overflow_q   <= overflow_d;
      char_q       <= char_d;
      clr_addr_q   <= clr_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
    end
  end

`ifdef UART_TEXT_GOTO_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) goto_col_q <= '0;
    else         goto_col_q <= goto_col_d;
  end
`endif

  assign bus.wr_en_o      = wr_en_q;
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.cursor_col_o = cur_col;
  assign bus.cursor_row_o = cur_row;
  assign bus.busy_o       = busy_q;
  assign bus.overflow_o   = overflow_q;

endmodule
